// File: rtl/tflip_pkg.sv
// Shared constants and types for the t_flip toggle register family.
// The optional edge counter width lives here so callers can size their sinks.
package tflip_pkg;

  localparam int unsigned TFLIP_CNT_W     = 16;
  localparam logic        TFLIP_RESET_BIT = 1'b0;

  typedef logic [TFLIP_CNT_W-1:0] tflip_cnt_t;

endpackage : tflip_pkg

// File: rtl/t_flip_bit.sv
// Single-bit toggle cell: state inverts on a rising clk edge when t is high.
// One cycle from t sampled to q change; async active-low reset, no backpressure.
module t_flip_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic state_q;
  logic state_d;

  always_comb begin
    state_d = state_q;
    if (t) begin
      state_d = ~state_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule : t_flip_bit

// File: rtl/t_flip.sv
// WIDTH independent toggle bits, one cycle t->q latency, qbar = ~q combinationally.
// Define TFLIP_TOGGLE_CNT_EN to add the toggle_cnt edge counter and toggled flag.
module t_flip
  import tflip_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{TFLIP_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
`ifdef TFLIP_TOGGLE_CNT_EN
  ,
  output tflip_cnt_t       toggle_cnt,
  output logic             toggled
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_flip_bit #(
      .RESET_VAL(RESET_VAL[i])
    ) u_bit (
      .clk(clk),
      .rst(rst),
      .t  (t[i]),
      .q  (q[i])
    );
  end

  assign qbar = ~q;

`ifdef TFLIP_TOGGLE_CNT_EN
  // Outside reset, any high t bit at an edge means q changed at that edge.
  logic       any_tgl;
  tflip_cnt_t cnt_q;
  tflip_cnt_t cnt_d;
  logic       toggled_q;
  logic       toggled_d;

  always_comb begin
    any_tgl   = |t;
    toggled_d = any_tgl;
    cnt_d     = cnt_q;
    if (any_tgl) begin
      cnt_d = cnt_q + tflip_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      toggled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      toggled_q <= toggled_d;
    end
  end

  assign toggle_cnt = cnt_q;
  assign toggled    = toggled_q;
`endif

endmodule : t_flip

// File: tb/tb_t_flip.sv
// Bench for t_flip: directed reset/toggle/glitch cases plus randomized t
// against a per-edge XOR model, for WIDTH=1 and WIDTH=4 instances.
module tb_t_flip;

  logic       clk;
  logic       rst;
  logic       t1;
  logic [3:0] t4;
  logic       q1;
  logic       qb1;
  logic [3:0] q4;
  logic [3:0] qb4;
`ifdef TFLIP_TOGGLE_CNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt4;
  logic        tgd1;
  logic        tgd4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference state: q after each edge is q xor the t sampled there.
  logic        mq1;
  logic [3:0]  mq4;
  logic [15:0] mcnt1;
  logic [15:0] mcnt4;
  logic        mtgd1;
  logic        mtgd4;

  t_flip #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .t   (t1),
    .q   (q1),
    .qbar(qb1)
`ifdef TFLIP_TOGGLE_CNT_EN
    ,
    .toggle_cnt(cnt1),
    .toggled   (tgd1)
`endif
  );

  t_flip #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .t   (t4),
    .q   (q4),
    .qbar(qb4)
`ifdef TFLIP_TOGGLE_CNT_EN
    ,
    .toggle_cnt(cnt4),
    .toggled   (tgd4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq1 = 1'b0;  mq4 = 4'h0;
      mcnt1 = 16'd0; mcnt4 = 16'd0;
      mtgd1 = 1'b0; mtgd4 = 1'b0;
    end else begin
      mq1 = mq1 ^ t1;
      mq4 = mq4 ^ t4;
      mtgd1 = (t1 != 1'b0);
      mtgd4 = (t4 != 4'h0);
      if (mtgd1) mcnt1 = mcnt1 + 16'd1;
      if (mtgd4) mcnt4 = mcnt4 + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q1", {63'd0, q1}, {63'd0, mq1});
      check("model_q4", {60'd0, q4}, {60'd0, mq4});
      check("qbar1", {63'd0, qb1}, {63'd0, ~q1});
      check("qbar4", {60'd0, qb4}, {60'd0, ~q4});
`ifdef TFLIP_TOGGLE_CNT_EN
      check("cnt1", {48'd0, cnt1}, {48'd0, mcnt1});
      check("cnt4", {48'd0, cnt4}, {48'd0, mcnt4});
      check("toggled1", {63'd0, tgd1}, {63'd0, mtgd1});
      check("toggled4", {63'd0, tgd4}, {63'd0, mtgd4});
`endif
    end
  end

  // Directed literal checks of both instances after an edge.
  task automatic expect_q(input string name, input logic e1, input logic [3:0] e4);
    check({name, "_q1"}, {63'd0, q1}, {63'd0, e1});
    check({name, "_qb1"}, {63'd0, qb1}, {63'd0, ~e1});
    check({name, "_q4"}, {60'd0, q4}, {60'd0, e4});
    check({name, "_qb4"}, {60'd0, qb4}, {60'd0, ~e4});
  endtask

  initial begin
    int elapsed;
    int d;
    rst = 1'b1;
    t1  = 1'b0;
    t4  = 4'h0;
    #1;
    rst = 1'b0;
    t1  = 1'b1;
    t4  = 4'hF;
    #1;
    expect_q("reset_async", 1'b0, 4'h0);
    chk_en = 1'b1;

    // Reset held with t high: nothing toggles.
    repeat (4) begin
      @(posedge clk); #1;
      expect_q("reset_hold", 1'b0, 4'h0);
    end

    // Release with t low.
    t1 = 1'b0; t4 = 4'h0;
    #1 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      expect_q("release_t0", 1'b0, 4'h0);
    end

    // Continuous toggle: divide-by-2.
    t1 = 1'b1; t4 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      expect_q("cont_toggle", (k % 2 == 0), (k % 2 == 0) ? 4'hF : 4'h0);
    end

    // Pulse strictly between edges must be ignored.
    t1 = 1'b0; t4 = 4'h0;
    @(posedge clk); #1;
    #2 begin t1 = 1'b1; t4 = 4'hA; end
    #2 begin t1 = 1'b0; t4 = 4'h0; end
    @(posedge clk); #1;
    expect_q("glitch", 1'b0, 4'h0);

    // Async reset mid-run overrides a pending toggle.
    t1 = 1'b1; t4 = 4'h5;
    @(posedge clk); #1;
    expect_q("pre_rst", 1'b1, 4'h5);
    #2 rst = 1'b0;
    #1;
    expect_q("mid_rst", 1'b0, 4'h0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    expect_q("post_rst", 1'b1, 4'h5);

    // Randomized t with changes at random offsets between edges.
    for (int it = 0; it < 48; it++) begin
      @(posedge clk); #1;
      elapsed = 1;
      repeat (3) begin
        d = $urandom_range(0, 7);
        if (elapsed + d < 9) begin
          #d;
          elapsed += d;
          t1 = 1'($urandom);
          t4 = 4'($urandom);
        end
      end
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_t_flip
